// File: rtl/if_stage_ctrl_if.sv
// Instruction-memory fetch bus: request/address out of the IF stage, ack/data back.
interface if_stage_ctrl_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;

    modport master (output imem_req_o, output imem_addr_o,
                    input  imem_ack_i, input  imem_data_i);
    modport slave  (input  imem_req_o, input  imem_addr_o,
                    output imem_ack_i, output imem_data_i);
endinterface

// File: rtl/if_stage_ctrl.sv
// IF stage controller: owns the PC and the IF/ID register, fetches over a req/ack bus,
// and parks a fetch that returns during an IF/ID stall in a one-entry skid buffer.
module if_stage_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   pc_stall_i,
    input  logic                   if_id_stall_i,
    input  logic                   flush_i,
    input  logic [31:0]            branch_target_i,
    if_stage_ctrl_if.master        imem,
    output logic [31:0]            if_id_pc_o,
    output logic [31:0]            if_id_instr_o,
    output logic                   if_id_valid_o
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_pc;
    logic        r_discard;
    logic [31:0] r_target;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4       = r_pc + 32'd4;
    assign imem.imem_req_o  = r_req;
    // The PC is left untouched while a discarded fetch is outstanding, so the address stays stable.
    assign imem.imem_addr_o = r_pc;
    assign if_id_pc_o       = r_if_id_pc;
    assign if_id_instr_o    = r_if_id_instr;
    assign if_id_valid_o    = r_if_id_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_req         <= 1'b0;
            r_pc          <= RESET_PC;
            r_discard     <= 1'b0;
            r_target      <= 32'h0;
            r_skid_pc     <= 32'h0;
            r_skid_instr  <= 32'h0;
            r_if_id_pc    <= 32'h0;
            r_if_id_instr <= 32'h0;
            r_if_id_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= FETCH;
                        r_req   <= 1'b1;
                    end
                end
                FETCH, HOLD: begin
                    if (flush_i) begin
                        r_if_id_pc    <= 32'h0;
                        r_if_id_instr <= 32'h0;
                        r_if_id_valid <= 1'b0;
                        if (r_state == HOLD || imem.imem_ack_i) begin
                            r_pc      <= branch_target_i;
                            r_discard <= 1'b0;
                            r_state   <= FETCH;
                            r_req     <= 1'b1;
                        end else begin
                            r_discard <= 1'b1;
                            r_target  <= branch_target_i;
                        end
                    end else if (r_state == FETCH) begin
                        if (imem.imem_ack_i && r_discard) begin
                            r_discard <= 1'b0;
                            r_pc      <= r_target;
                            if (!if_id_stall_i) begin
                                r_if_id_pc    <= 32'h0;
                                r_if_id_instr <= 32'h0;
                                r_if_id_valid <= 1'b0;
                            end
                        end else if (imem.imem_ack_i) begin
                            if (!if_id_stall_i) begin
                                r_if_id_pc    <= w_pc_plus4;
                                r_if_id_instr <= imem.imem_data_i;
                                r_if_id_valid <= 1'b1;
                                if (!pc_stall_i) r_pc <= w_pc_plus4;
                            end else begin
                                r_skid_pc    <= w_pc_plus4;
                                r_skid_instr <= imem.imem_data_i;
                                r_pc         <= w_pc_plus4;
                                r_state      <= HOLD;
                                r_req        <= 1'b0;
                            end
                        end else if (!if_id_stall_i) begin
                            r_if_id_pc    <= 32'h0;
                            r_if_id_instr <= 32'h0;
                            r_if_id_valid <= 1'b0;
                        end
                    end else if (!if_id_stall_i) begin
                        // HOLD always has a full skid buffer; draining it resumes fetching.
                        r_if_id_pc    <= r_skid_pc;
                        r_if_id_instr <= r_skid_instr;
                        r_if_id_valid <= 1'b1;
                        r_state       <= FETCH;
                        r_req         <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Randomized bench for if_stage_ctrl against a queue-based behavioural model of the IF stage.
module tb_if_stage_ctrl;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        pc_stall_i = 1'b0;
    logic        if_id_stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;

    if_stage_ctrl_if imem_bus();

    if_stage_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .pc_stall_i(pc_stall_i), .if_id_stall_i(if_id_stall_i),
        .flush_i(flush_i), .branch_target_i(branch_target_i),
        .imem(imem_bus.master),
        .if_id_pc_o(if_id_pc_o), .if_id_instr_o(if_id_instr_o),
        .if_id_valid_o(if_id_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int errs = 0;
    int checks = 0;

    // Reference model: running flag, PC, skid contents as a queue, pending redirect as a queue.
    bit          m_run;
    logic [31:0] m_pc;
    logic [63:0] m_skid[$];
    logic [31:0] m_redir[$];
    logic        m_vld;
    logic [31:0] m_ipc;
    logic [31:0] m_ins;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_pc = RST_PC; m_skid.delete(); m_redir.delete();
        m_vld = 0; m_ipc = 0; m_ins = 0;
    endfunction

    function automatic void bubble();
        m_vld = 0; m_ipc = 0; m_ins = 0;
    endfunction

    function automatic void model_step(input bit st, input bit ps, input bit is, input bit fl,
                                       input logic [31:0] tg, input bit ack, input logic [31:0] dat);
        bit req;
        logic [63:0] e;
        if (!m_run) begin
            if (st) m_run = 1;
            return;
        end
        req = (m_skid.size() == 0);
        if (fl) begin
            bubble();
            m_skid.delete();
            m_redir.delete();
            if (!req || ack) m_pc = tg;
            else m_redir.push_back(tg);
        end else if (!req) begin
            if (!is) begin
                e = m_skid.pop_front();
                m_vld = 1; m_ipc = e[63:32]; m_ins = e[31:0];
            end
        end else if (ack && m_redir.size() != 0) begin
            m_pc = m_redir.pop_front();
            if (!is) bubble();
        end else if (ack) begin
            if (!is) begin
                m_vld = 1; m_ipc = m_pc + 32'd4; m_ins = dat;
                if (!ps) m_pc = m_pc + 32'd4;
            end else begin
                m_skid.push_back({m_pc + 32'd4, dat});
                m_pc = m_pc + 32'd4;
            end
        end else if (!is) begin
            bubble();
        end
    endfunction

    task automatic check_outputs();
        chk("req", {31'h0, imem_bus.imem_req_o}, {31'h0, (m_run && m_skid.size() == 0)});
        chk("addr", imem_bus.imem_addr_o, m_pc);
        chk("valid", {31'h0, if_id_valid_o}, {31'h0, m_vld});
        chk("instr", if_id_instr_o, m_vld ? m_ins : 32'h0);
        if (m_vld) chk("if_id_pc", if_id_pc_o, m_ipc);
    endtask

    // am: 0 no ack, 1 ack whenever requesting, 2 random ack while requesting, 3 forced ack
    task automatic step(input bit st, input bit ps, input bit is, input bit fl,
                        input logic [31:0] tg, input int am);
        bit req_m, ack;
        check_outputs();
        req_m = m_run && (m_skid.size() == 0);
        case (am)
            1: ack = req_m;
            2: ack = req_m && ($urandom_range(0, 2) != 0);
            3: ack = 1'b1;
            default: ack = 1'b0;
        endcase
        start_i = st; pc_stall_i = ps; if_id_stall_i = is; flush_i = fl; branch_target_i = tg;
        imem_bus.imem_ack_i  = ack;
        imem_bus.imem_data_i = mem(m_pc);
        model_step(st, ps, is, fl, tg, ack, mem(m_pc));
        @(negedge clk_i);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"}, {31'h0, imem_bus.imem_req_o}, 32'h0);
        chk({tag, "_addr"}, imem_bus.imem_addr_o, RST_PC);
        chk({tag, "_valid"}, {31'h0, if_id_valid_o}, 32'h0);
        chk({tag, "_instr"}, if_id_instr_o, 32'h0);
        chk({tag, "_pc"}, if_id_pc_o, 32'h0);
    endtask

    initial begin
        bit st, ps, is, fl;
        logic [31:0] tg;
        imem_bus.imem_ack_i = 1'b0;
        imem_bus.imem_data_i = 32'h0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_reset_values("reset");
        rst_i = 1'b0;

        // Zero-wait streaming from RESET_PC.
        step(1, 0, 0, 0, 0, 1);
        repeat (5) step(0, 0, 0, 0, 0, 1);

        // Two-cycle stall with an ack in the first cycle, then release.
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 0, 1);

        // Three-cycle latency with a flush to 0x40 in the first wait cycle.
        step(0, 0, 0, 1, 32'h40, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("redirect_addr", imem_bus.imem_addr_o, 32'h40);
        repeat (3) step(0, 0, 0, 0, 0, 1);

        // Flush and IF/ID stall together: flush wins.
        step(0, 1, 1, 1, 32'h100, 1);
        chk("flush_stall_valid", {31'h0, if_id_valid_o}, 32'h0);
        chk("flush_stall_addr", imem_bus.imem_addr_o, 32'h100);
        repeat (2) step(0, 0, 0, 0, 0, 1);

        // PC wrap at the top of the address space.
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("wrap_addr", imem_bus.imem_addr_o, 32'h0);
        chk("wrap_if_id_pc", if_id_pc_o, 32'h0);
        repeat (2) step(0, 0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 7) == 0);
            is = ($urandom_range(0, 3) == 0);
            ps = ($urandom_range(0, 4) == 0) ? ~is : is;
            fl = ($urandom_range(0, 11) == 0);
            tg = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            step(st, ps, is, fl, tg, ($urandom_range(0, 1) == 0) ? 1 : 2);
        end

        // Reset asserted while a request is outstanding.
        step(0, 0, 0, 1, 32'h200, 1);
        step(0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        start_i = 0; pc_stall_i = 0; if_id_stall_i = 0; flush_i = 0; branch_target_i = 0;
        imem_bus.imem_ack_i = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        step(0, 0, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0, 3);
        step(1, 0, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 0, 1);
        check_outputs();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/if_stage_ctrl.md
# if_stage_ctrl

Instruction-fetch stage controller for the 5-stage MIPS pipeline. It owns the PC and the IF/ID pipeline register, and drives a request/acknowledge fetch interface to instruction memory. It consumes the stall outputs of the load-use hazard logic (PC stall, IF/ID stall) and the branch flush from ID. A one-entry skid buffer ensures that a fetch returning during a stall is never lost or duplicated.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk_i` input, 1 bit: pipeline clock. All state changes on its rising edge.
- `rst_i` input, 1 bit: asynchronous, active-high reset.
- `start_i` input, 1 bit: begin fetching. Sampled only in IDLE.
- `pc_stall_i` input, 1 bit: hold the PC.
- `if_id_stall_i` input, 1 bit: hold the IF/ID register.
- `flush_i` input, 1 bit: taken branch or jump resolved in ID.
- `branch_target_i` input, 32 bits: new PC when `flush_i` is high.
- `imem_req_o` output, 1 bit: fetch request.
- `imem_addr_o` output, 32 bits: fetch address. Stable while `imem_req_o` is high and no ack has arrived.
- `imem_ack_i` input, 1 bit: `imem_data_i` is valid this cycle.
- `imem_data_i` input, 32 bits: fetched instruction.
- `if_id_pc_o` output, 32 bits: PC+4 of the instruction held in IF/ID.
- `if_id_instr_o` output, 32 bits: instruction held in IF/ID; 32'h0 (nop) when invalid.
- `if_id_valid_o` output, 1 bit: IF/ID holds a real instruction.

## Operation
- States: IDLE, FETCH, HOLD.
- Reset values:
  - state IDLE; `pc` = RESET_PC; discard flag = 0; skid buffer empty.
  - `imem_req_o` = 0; `imem_addr_o` = RESET_PC.
  - `if_id_pc_o` = 0, `if_id_instr_o` = 0, `if_id_valid_o` = 0.
- IDLE: `imem_req_o` = 0. Go to FETCH when `start_i` = 1.
- FETCH:
  - `imem_req_o` = 1; `imem_addr_o` = `pc`.
  - On `imem_ack_i` with the discard flag clear:
    - If `if_id_stall_i` = 0: IF/ID loads {`pc`+4, `imem_data_i`, valid = 1}. `pc` <= `pc`+4 unless `pc_stall_i` = 1. Stay in FETCH.
    - If `if_id_stall_i` = 1: the skid buffer captures {`pc`+4, `imem_data_i`}. `pc` <= `pc`+4. IF/ID holds. Go to HOLD.
  - On `imem_ack_i` with the discard flag set: drop the data, clear the flag, `pc` <= saved target.
  - No ack: IF/ID holds if stalled. Otherwise IF/ID loads the bubble (nop, valid = 0).
- HOLD:
  - `imem_req_o` = 0.
  - When `if_id_stall_i` = 0: IF/ID loads from the skid buffer, the buffer empties, go to FETCH.
- Flush (`flush_i` = 1) has priority over both stalls and over ack:
  - IF/ID loads the bubble; skid buffer empties.
  - Ack this cycle or no request outstanding: `pc` <= `branch_target_i` and state FETCH (from FETCH or HOLD).
  - Request outstanding without ack: set the discard flag, save `branch_target_i`, keep `imem_addr_o` stable until ack.
- `pc_stall_i` and `if_id_stall_i` are asserted together by the hazard logic. Each is still honoured independently as specified above.
- Arithmetic: PC increment is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

## Timing
- Zero-wait memory (ack in the same cycle as req) gives one instruction per cycle.
- Ack in cycle N: IF/ID is visible in cycle N+1, and `imem_addr_o` shows the next PC in cycle N+1.
- Stall released in cycle M while in HOLD: the skid instruction is in IF/ID in M+1; the next request is issued in M+1.
- Flush in cycle F with no outstanding miss: the request to the target is issued in F+1; the bubble is in IF/ID in F+1.
- `rst_i` asserted mid-fetch: all state returns to reset values immediately. A later stray ack is ignored because IDLE has no request.

## Test plan
- Zero-wait memory, RESET_PC = 0, `start_i` pulse → addresses 0, 4, 8 on consecutive cycles; IF/ID shows {4, instr@0} then {8, instr@4}.
- `if_id_stall_i` and `pc_stall_i` high for 2 cycles while ack = 1 in the first of them → IF/ID holds; HOLD is entered; after release, IF/ID shows the buffered instruction once with no duplication; the next address is the PC+4 of that instruction.
- Memory with 3-cycle latency, `flush_i` with target 32'h40 in wait cycle 1 → `imem_addr_o` stays stable until ack; the returned data is dropped; the next request is to 32'h40; IF/ID valid = 0 in the meantime.
- `flush_i` and `if_id_stall_i` in the same cycle → the flush wins: IF/ID is a nop with valid = 0, and the next address equals the target.
- `pc` = 32'hFFFF_FFFC with ack → the next address is 32'h0 and `if_id_pc_o` = 0.
- `rst_i` pulsed during an outstanding request → all outputs return to reset values; fetch restarts only after a new `start_i`.
